fpu_seq: RTL and testbench

Issue sequencer placed directly upstream of the FPU datapath. It accepts one floating-point operation per handshake from the core and resolves the rounding mode against `fcsr`. It holds the operands and opcode stable at the FPU inputs for the operation's fixed latency, then captures the FPU result and presents it to writeback with a valid/ready handshake. It also rejects illegal opcodes and rounding modes without starting the FPU.

---
 rtl/fpu_seq.sv | 115 +++++++++++
 tb/tb_fpu_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_seq.sv
// fpu_seq: issue sequencer that holds an FPU op for its fixed latency and hands the result to writeback
module fpu_seq #(
  parameter int unsigned ADD_LAT  = 3,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned DIV_LAT  = 12,
  parameter int unsigned SQRT_LAT = 12,
  parameter int unsigned CVT_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [2:0]  in_rm,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] fcsr,
  output logic [5:0]  fpu_op,
  output logic [31:0] fpu_rs1,
  output logic [31:0] fpu_rs2,
  output logic [2:0]  fpu_rm,
  input  logic [31:0] fpu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_illegal,
  output logic        busy,
  input  logic        flush
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [4:0] L_ADD  = 5'(ADD_LAT);
  localparam logic [4:0] L_MUL  = 5'(MUL_LAT);
  localparam logic [4:0] L_DIV  = 5'(DIV_LAT);
  localparam logic [4:0] L_SQRT = 5'(SQRT_LAT);
  localparam logic [4:0] L_CVT  = 5'(CVT_LAT);
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [5:0]  fpu_op_q, fpu_op_d;
  logic [31:0] fpu_rs1_q, fpu_rs1_d, fpu_rs2_q, fpu_rs2_d;
  logic [2:0]  fpu_rm_q, fpu_rm_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_illegal_q, out_illegal_d;
  logic [2:0]  rm_res;
  logic [4:0]  lat;
  logic        illegal, accept, take;
  logic        unused_fcsr;
  assign unused_fcsr = ^{fcsr[31:8], fcsr[4:0]};
  assign rm_res  = (in_rm == 3'd7) ? fcsr[7:5] : in_rm;
  assign illegal = (in_op > 6'd5) | (rm_res >= 3'd5);
  assign lat = (in_op == 6'd0) ? L_ADD : (in_op == 6'd1) ? L_MUL : (in_op == 6'd2) ? L_DIV :
               (in_op == 6'd3) ? L_SQRT : L_CVT;
  assign in_ready    = (state_q == IDLE) & ~reset;
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign accept      = in_valid & in_ready;
  assign take        = accept & ~flush;
  assign fpu_op      = fpu_op_q;
  assign fpu_rs1     = fpu_rs1_q;
  assign fpu_rs2     = fpu_rs2_q;
  assign fpu_rm      = fpu_rm_q;
  assign out_data    = out_data_q;
  assign out_illegal = out_illegal_q;
  // next-state: flush wins, then accept from IDLE, countdown in EXEC, handshake in DONE
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    out_data_d    = out_data_q;
    out_illegal_d = out_illegal_q;
    fpu_op_d      = take ? in_op : fpu_op_q;
    fpu_rs1_d     = take ? in_rs1 : fpu_rs1_q;
    fpu_rs2_d     = take ? in_rs2 : fpu_rs2_q;
    fpu_rm_d      = take ? rm_res : fpu_rm_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        state_d       = illegal ? DONE : EXEC;
        cnt_d         = illegal ? cnt_q : lat;
        out_data_d    = illegal ? 32'd0 : out_data_q;
        out_illegal_d = illegal;
      end
    end else if (state_q == EXEC) begin
      cnt_d      = cnt_q - 5'd1;
      state_d    = (cnt_q == 5'd1) ? DONE : EXEC;
      out_data_d = (cnt_q == 5'd1) ? fpu_result : out_data_q;
    end else begin
      state_d = out_ready ? IDLE : DONE;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 5'd0;
      fpu_op_q      <= 6'd0;
      fpu_rs1_q     <= 32'd0;
      fpu_rs2_q     <= 32'd0;
      fpu_rm_q      <= 3'd0;
      out_data_q    <= 32'd0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fpu_op_q      <= fpu_op_d;
      fpu_rs1_q     <= fpu_rs1_d;
      fpu_rs2_q     <= fpu_rs2_d;
      fpu_rm_q      <= fpu_rm_d;
      out_data_q    <= out_data_d;
      out_illegal_q <= out_illegal_d;
    end
  end
endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: randomized self-checking bench for fpu_seq against a latency/legality model
module tb_fpu_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op = '0;
  logic [2:0]  in_rm = '0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0, fcsr = '0;
  logic [5:0]  fpu_op;
  logic [31:0] fpu_rs1, fpu_rs2;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_illegal, busy;
  logic        flush = 1'b0;
  int total = 0;
  int bad = 0;
  int lat_tab[6] = '{3, 3, 12, 12, 1, 1};

  fpu_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rm(in_rm), .in_rs1(in_rs1), .in_rs2(in_rs2), .fcsr(fcsr), .fpu_op(fpu_op),
    .fpu_rs1(fpu_rs1), .fpu_rs2(fpu_rs2), .fpu_rm(fpu_rm), .fpu_result(fpu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_illegal(out_illegal), .busy(busy), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [5:0] op, input logic [2:0] rm, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] fcsr_v, input int stall);
    logic [2:0]  exp_rm;
    logic        exp_ill;
    int          exp_lat;
    logic [31:0] exp_data;
    exp_rm  = (rm == 3'd7) ? fcsr_v[7:5] : rm;
    exp_ill = (op > 6'd5) || (exp_rm >= 3'd5);
    exp_lat = exp_ill ? 0 : lat_tab[op];
    exp_data = 32'd0;
    in_op = op; in_rm = rm; in_rs1 = rs1; in_rs2 = rs2; fcsr = fcsr_v; in_valid = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL pre_accept_in_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++;
    if ({fpu_op, fpu_rs1, fpu_rs2, fpu_rm} !== {op, rs1, rs2, exp_rm}) begin
      bad++;
      $display("FAIL fpu_regs op=%0d rs1=%h rs2=%h rm=%0d want op=%0d rs1=%h rs2=%h rm=%0d",
               fpu_op, fpu_rs1, fpu_rs2, fpu_rm, op, rs1, rs2, exp_rm);
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_accept got=%b want=1", busy); end
    for (int k = 1; k <= exp_lat; k++) begin
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || fpu_rm !== exp_rm) begin
        bad++;
        $display("FAIL exec_cycle%0d out_valid=%b in_ready=%b fpu_rm=%0d want 0/0/%0d op=%0d",
                 k, out_valid, in_ready, fpu_rm, exp_rm, op);
      end
      fpu_result = $urandom;
      exp_data = fpu_result;
      fcsr = $urandom;
      in_rm = 3'($urandom);
      tick();
    end
    for (int s = 0; s <= stall; s++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_data || out_illegal !== exp_ill || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL done_hold%0d op=%0d valid=%b data=%h ill=%b in_ready=%b want 1/%h/%b/0",
                 s, op, out_valid, out_data, out_illegal, in_ready, exp_data, exp_ill);
      end
      if (s < stall) begin
        fpu_result = $urandom;
        tick();
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release op=%0d valid=%b busy=%b in_ready=%b want 0/0/1", op, out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    tick();
    total++;
    if ({in_ready, out_valid, busy, out_illegal} !== 4'b0000 ||
        {fpu_op, fpu_rs1, fpu_rs2, fpu_rm, out_data} !== 105'd0) begin
      bad++;
      $display("FAIL reset_values in_ready=%b valid=%b busy=%b ill=%b op=%0d data=%h",
               in_ready, out_valid, busy, out_illegal, fpu_op, out_data);
    end
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
    tick();
  endtask

  task automatic test_cvt();
    run_op(6'd4, 3'd0, 32'h0000_0005, 32'h0, 32'h0, 0);
    run_op(6'd5, 3'd1, 32'hFFFF_FFFF, 32'h1234, 32'h0, 1);
  endtask

  task automatic test_div_dyn();
    run_op(6'd2, 3'd7, 32'h4000_0000, 32'h3F80_0000, 32'h0000_0060, 0);
  endtask

  task automatic test_illegal();
    run_op(6'd6, 3'd0, 32'hDEAD_BEEF, 32'h1, 32'h0, 0);
    run_op(6'd0, 3'd7, 32'h1, 32'h2, 32'h0000_00A0, 0);
    run_op(6'd1, 3'd6, 32'h3, 32'h4, 32'h0, 2);
  endtask

  task automatic test_stall();
    run_op(6'd0, 3'd2, 32'h3F80_0000, 32'h4000_0000, 32'h0, 5);
  endtask

  task automatic test_flush();
    in_op = 6'd3; in_rm = 3'd1; in_rs1 = 32'h4080_0000; in_rs2 = 32'h0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin fpu_result = $urandom; tick(); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || fpu_op !== 6'd3) begin
      bad++;
      $display("FAIL flush_exec busy=%b valid=%b in_ready=%b fpu_op=%0d want 0/0/1/3", busy, out_valid, in_ready, fpu_op);
    end
    in_op = 6'd1; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    total++;
    if (busy !== 1'b0 || fpu_op !== 6'd3) begin
      bad++;
      $display("FAIL flush_over_accept busy=%b fpu_op=%0d want 0/3", busy, fpu_op);
    end
    for (int k = 0; k < 12; k++) begin
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_valid cyc=%0d got=%b want=0", k, out_valid); end
      tick();
    end
    run_op(6'd1, 3'd0, 32'h11, 32'h22, 32'h0, 0);
  endtask

  task automatic test_async_reset();
    in_op = 6'd2; in_rm = 3'd0; in_rs1 = 32'hABCD_0001; in_rs2 = 32'h5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, busy, out_illegal} !== 4'b0000 ||
        {fpu_op, fpu_rs1, fpu_rs2, fpu_rm} !== 73'd0) begin
      bad++;
      $display("FAIL async_reset in_ready=%b valid=%b busy=%b op=%0d rs1=%h want all 0",
               in_ready, out_valid, busy, fpu_op, fpu_rs1);
    end
    tick();
    #2 reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL async_reset_no_valid cyc=%0d valid=%b busy=%b want 0/0", k, out_valid, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_op(6'(i), 3'd0, $urandom, $urandom, 32'h0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_op(6'($urandom_range(0, 7)), 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 2));
  endtask

  initial begin
    test_reset();
    test_cvt();
    test_div_dyn();
    test_illegal();
    test_stall();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
